// File: rtl/oled_pkg.sv
// oled_pkg: shared widths and FSM encoding for the OLED framebuffer arbiter
package oled_pkg;

    localparam int unsigned OLED_X_BITS     = 7;
    localparam int unsigned OLED_Y_BITS     = 7;
    localparam int unsigned OLED_ADDR_BITS  = OLED_Y_BITS + OLED_X_BITS;
    localparam int unsigned OLED_COLOR_BITS = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RD_ISSUE   = 2'd1,
        RD_CAPTURE = 2'd2
    } oled_state_e;

endpackage

// File: rtl/oled_fb_arbiter.sv
// oled_fb_arbiter: shares one single-port framebuffer between scan reads and camera writes
// Ports: clk/reset (sync, active-high); scan_* read requester with registered scan_color
// and frame_start pulse; cam_* valid/ready write requester; mem_* external RAM port
// (address {y,x}, 1-cycle read latency); stall_count saturating camera back-pressure count.
module oled_fb_arbiter
    import oled_pkg::*;
#(
    parameter int unsigned C_X_BITS     = OLED_X_BITS,
    parameter int unsigned C_Y_BITS     = OLED_Y_BITS,
    parameter int unsigned C_COLOR_BITS = OLED_COLOR_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [C_X_BITS-1:0]          scan_x,
    input  logic [C_Y_BITS-1:0]          scan_y,
    input  logic                         scan_next,
    output logic [C_COLOR_BITS-1:0]      scan_color,
    input  logic                         cam_valid,
    output logic                         cam_ready,
    input  logic [C_X_BITS-1:0]          cam_x,
    input  logic [C_Y_BITS-1:0]          cam_y,
    input  logic [C_COLOR_BITS-1:0]      cam_data,
    output logic [C_Y_BITS+C_X_BITS-1:0] mem_addr,
    output logic                         mem_we,
    output logic [C_COLOR_BITS-1:0]      mem_wdata,
    input  logic [C_COLOR_BITS-1:0]      mem_rdata,
    output logic                         frame_start,
    output logic [15:0]                  stall_count
);

    localparam int unsigned C_ADDR_BITS = C_Y_BITS + C_X_BITS;

    oled_state_e             state_q, state_d;
    logic [C_ADDR_BITS-1:0]  addr_q, addr_d;
    logic                    we_q, we_d;
    logic [C_COLOR_BITS-1:0] wdata_q, wdata_d;
    logic [C_COLOR_BITS-1:0] color_q, color_d;
    logic                    fs_q, fs_d;
    logic [15:0]             stall_q, stall_d;
    logic                    rd_go, wr_go;

    // Reads always beat writes; the camera only sees ready on genuinely free cycles.
    assign cam_ready = !reset && state_q == IDLE && !scan_next;
    assign rd_go     = state_q == IDLE && scan_next;
    assign wr_go     = cam_valid && cam_ready;

    always_comb begin
        state_d = state_q == IDLE     ? (scan_next ? RD_ISSUE : IDLE) :
                  state_q == RD_ISSUE ? RD_CAPTURE : IDLE;
        addr_d  = rd_go ? {scan_y, scan_x} : wr_go ? {cam_y, cam_x} : addr_q;
        we_d    = wr_go;
        wdata_d = wr_go ? cam_data : wdata_q;
        // RAM data for the address presented in RD_ISSUE arrives during RD_CAPTURE.
        color_d = state_q == RD_CAPTURE ? mem_rdata : color_q;
        fs_d    = rd_go && scan_x == '0 && scan_y == '0;
        stall_d = (cam_valid && !cam_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            color_q <= '0;
            fs_q    <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            color_q <= color_d;
            fs_q    <= fs_d;
            stall_q <= stall_d;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_we      = we_q;
    assign mem_wdata   = wdata_q;
    assign scan_color  = color_q;
    assign frame_start = fs_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_oled_fb_arbiter.sv
// tb_oled_fb_arbiter: self-checking bench with a transaction-level reference model
module tb_oled_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  scan_x = '0, scan_y = '0, cam_x = '0, cam_y = '0;
    logic        scan_next = 1'b0, cam_valid = 1'b0;
    logic [15:0] cam_data = '0;
    logic [15:0] scan_color, mem_wdata, stall_count;
    logic [15:0] mem_rdata;
    logic        cam_ready, mem_we, frame_start;
    logic [13:0] mem_addr;

    always #5 clk = ~clk;

    oled_fb_arbiter dut (
        .clk(clk), .reset(reset),
        .scan_x(scan_x), .scan_y(scan_y), .scan_next(scan_next), .scan_color(scan_color),
        .cam_valid(cam_valid), .cam_ready(cam_ready), .cam_x(cam_x), .cam_y(cam_y),
        .cam_data(cam_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .frame_start(frame_start), .stall_count(stall_count)
    );

    // External single-port framebuffer, 1-cycle read latency.
    logic [15:0] ram [0:16383];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int          n_assert, n_fail;
    logic [15:0] refmem [0:16383];
    int          rd_phase, rd_addr, e_addr, e_stall;
    logic        e_we, e_fs, chk_addr, chk_wd, rdy_seen;
    logic [15:0] e_wdata, e_color;

    typedef struct {
        int          x, y;
        logic [15:0] d;
        int          addr;
        logic        fs;
    } rd_vec_t;
    rd_vec_t tbl [5];

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, check ready, advance model, check registered outputs.
    task automatic cyc(input logic r, input logic sn, input int sx, input int sy,
                       input logic cv, input int cx, input int cy, input logic [15:0] cd);
        logic e_rdy;
        reset = r; scan_next = sn; scan_x = sx[6:0]; scan_y = sy[6:0];
        cam_valid = cv; cam_x = cx[6:0]; cam_y = cy[6:0]; cam_data = cd;
        #1;
        e_rdy = !r && rd_phase == 0 && !sn;
        rdy_seen = cam_ready;
        chk("cam_ready", int'(cam_ready), int'(e_rdy));
        if (r) begin
            rd_phase = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_color = 0;
            e_fs = 0; e_stall = 0; chk_addr = 1; chk_wd = 1;
        end else begin
            if (cv && !e_rdy && e_stall < 65535) e_stall++;
            e_we = cv && e_rdy; e_fs = 0; chk_addr = 0; chk_wd = e_we;
            if (e_we) begin
                e_addr = cy * 128 + cx; e_wdata = cd; refmem[e_addr] = cd; chk_addr = 1;
            end
            if (rd_phase == 0 && sn) begin
                rd_addr = sy * 128 + sx; e_addr = rd_addr; chk_addr = 1;
                e_fs = (sx == 0 && sy == 0); rd_phase = 1;
            end else if (rd_phase == 1) rd_phase = 2;
            else if (rd_phase == 2) begin
                e_color = refmem[rd_addr]; rd_phase = 0;
            end
        end
        @(negedge clk);
        chk("mem_we", int'(mem_we), int'(e_we));
        if (chk_addr) chk("mem_addr", int'(mem_addr), e_addr);
        if (chk_wd) chk("mem_wdata", int'(mem_wdata), int'(e_wdata));
        chk("scan_color", int'(scan_color), int'(e_color));
        chk("frame_start", int'(frame_start), int'(e_fs));
        chk("stall_count", int'(stall_count), e_stall);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        n_assert = 0; n_fail = 0; rd_phase = 0;
        for (int i = 0; i < 16384; i++) refmem[i] = '0;
        tbl[0] = '{5, 3, 16'hF800, 389, 1'b0};
        tbl[1] = '{0, 0, 16'h1234, 0, 1'b1};
        tbl[2] = '{1, 0, 16'hABCD, 1, 1'b0};
        tbl[3] = '{127, 127, 16'hFFFF, 16383, 1'b0};
        tbl[4] = '{0, 1, 16'h0F0F, 128, 1'b0};
        @(negedge clk);

        cyc(1, 0, 0, 0, 1, 3, 3, 16'h5555);
        cyc(1, 0, 0, 0, 0, 0, 0, 16'h0);
        chk("rst_cam_ready", int'(rdy_seen), 0);
        chk("rst_stall", int'(stall_count), 0);
        idle();
        chk("post_rst_ready", int'(rdy_seen), 1);

        // Seed every address the random phase may read.
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                cyc(0, 0, 0, 0, 1, x, y, 16'((y * 8 + x) * 997 + 3));

        // Back-to-back camera writes.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, i, 0, 16'(i + 1));
            chk("b2b_we", int'(mem_we), 1);
            chk("b2b_addr", int'(mem_addr), i);
            chk("b2b_data", int'(mem_wdata), i + 1);
        end
        idle();

        // Table-driven write-then-read vectors.
        foreach (tbl[k]) begin
            cyc(0, 0, 0, 0, 1, tbl[k].x, tbl[k].y, tbl[k].d);
            idle(); idle();
            cyc(0, 1, tbl[k].x, tbl[k].y, 0, 0, 0, 16'h0);
            chk("tbl_rd_addr", int'(mem_addr), tbl[k].addr);
            chk("tbl_rd_we", int'(mem_we), 0);
            chk("tbl_frame_start", int'(frame_start), int'(tbl[k].fs));
            idle();
            chk("tbl_busy1", int'(rdy_seen), 0);
            idle();
            chk("tbl_busy2", int'(rdy_seen), 0);
            chk("tbl_color", int'(scan_color), int'(tbl[k].d));
            idle();
        end

        // Read and write requested together: read first, write kept and done at T+4.
        cyc(1, 0, 0, 0, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 1, 10, 2, 16'hBEEF);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 10, 2, 16'hBEEF);
        chk("coll_we", int'(mem_we), 1);
        chk("coll_addr", int'(mem_addr), 266);
        chk("coll_data", int'(mem_wdata), 16'hBEEF);
        chk("coll_stall", int'(stall_count), 3);
        idle();

        // Reset in the middle of a read abandons it.
        cyc(0, 1, 5, 3, 0, 0, 0, 16'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 16'h0);
        chk("abort_color", int'(scan_color), 0);
        chk("abort_we", int'(mem_we), 0);
        idle();
        chk("abort_ready", int'(rdy_seen), 1);
        idle(); idle(); idle();
        chk("abort_color_hold", int'(scan_color), 0);

        // Randomized traffic, including scan_next while a read is in flight.
        for (int i = 0; i < 3000; i++)
            cyc(0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                16'($urandom));
        idle(); idle(); idle();

        // Continuous stalls must saturate, not wrap.
        cyc(1, 0, 0, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 70000; i++) cyc(0, i % 3 == 0, 0, 0, 1, 1, 1, 16'h00AA);
        chk("stall_saturated", int'(stall_count), 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_fb_arbiter.md
OLED_FB_ARBITER -- requirements
Module: oled_fb_arbiter

Interface
REQ-001 SHALL have parameter C_X_BITS, default 7, scan/camera X coordinate width.
REQ-002 SHALL have parameter C_Y_BITS, default 7, scan/camera Y coordinate width.
REQ-003 SHALL have parameter C_COLOR_BITS, default 16, pixel width; 8 also legal.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports scan_x  in  C_X_BITS and scan_y  in  C_Y_BITS  coordinates from the OLED scan core.
REQ-007 SHALL have port scan_next  in  1  one-cycle pulse; scan_x/scan_y already hold the new coordinate in that cycle.
REQ-008 SHALL have port scan_color  out  C_COLOR_BITS  registered pixel returned to the scan core.
REQ-009 SHALL have ports cam_valid  in  1, cam_ready  out  1, cam_x  in  C_X_BITS, cam_y  in  C_Y_BITS, cam_data  in  C_COLOR_BITS  camera write requester.
REQ-010 SHALL have ports mem_addr  out  C_Y_BITS+C_X_BITS, mem_we  out  1, mem_wdata  out  C_COLOR_BITS, mem_rdata  in  C_COLOR_BITS  single-port framebuffer, 1-cycle read latency.
REQ-011 SHALL have port frame_start  out  1  one-cycle pulse at scan wrap to (0,0).
REQ-012 SHALL have port stall_count  out  16  saturating count of cycles with cam_valid=1 and cam_ready=0.

Function
REQ-013 SHALL address memory as {y,x}: y in MSBs, x in LSBs.
REQ-014 SHALL use FSM states IDLE, RD_ISSUE, RD_CAPTURE.
REQ-015 IDLE with scan_next=1 at cycle T SHALL latch {scan_y,scan_x} and go to RD_ISSUE; mem_addr = latched address, mem_we=0 at T+1.
REQ-016 RD_ISSUE SHALL go unconditionally to RD_CAPTURE; RD_CAPTURE SHALL load scan_color from mem_rdata and return to IDLE; new scan_color visible at T+3.
REQ-017 cam_ready SHALL be combinational: 1 only in IDLE with scan_next=0 and reset=0.
REQ-018 cam_valid&cam_ready at cycle T SHALL register mem_we=1, mem_addr={cam_y,cam_x}, mem_wdata=cam_data for T+1; FSM stays in IDLE; back-to-back writes every cycle SHALL be allowed.
REQ-019 mem_we SHALL be 0 in every cycle without a write handshake in the preceding cycle.
REQ-020 scan_next and cam_valid in the same cycle: read SHALL win; the write is held (cam_ready=0) and SHALL NOT be lost.
REQ-021 scan_next in RD_ISSUE/RD_CAPTURE SHALL be ignored (protocol guarantees >=32-cycle spacing); no state corruption.
REQ-022 frame_start SHALL pulse at T+1 when scan_next=1 at T with scan_x=0 and scan_y=0.
REQ-023 stall_count SHALL increment per stalled cycle and saturate at 0xFFFF.
REQ-024 scan_color SHALL otherwise hold its value between reads.

Reset
REQ-025 On reset: state IDLE, scan_color 0, mem_we 0, mem_addr 0, mem_wdata 0, frame_start 0, stall_count 0, cam_ready 0.
REQ-026 Reset during RD_ISSUE/RD_CAPTURE SHALL abandon the read; scan_color SHALL read 0, not memory data.
REQ-027 Reset coincident with a write handshake SHALL suppress that write (mem_we=0 next cycle).

Structure
REQ-028 Coordinate widths, address width {C_Y_BITS+C_X_BITS} and FSM state encoding SHALL live in shared package oled_pkg.
REQ-029 Single module; framebuffer RAM SHALL be external (instantiated beside it at top level, not inside).

Verification
REQ-030 scan_next at (5,3), mem holds 0xF800 at addr 389 -> mem_addr=389 at T+1, scan_color=0xF800 at T+3, cam_ready=0 for T..T+2.
REQ-031 cam_valid held 4 cycles, coords (0..3,0), data 0x0001..0x0004 -> four consecutive mem_we=1 cycles, addr 0..3, matching data.
REQ-032 scan_next and cam_valid same cycle -> read issued first, write performed at T+4 with original data, stall_count=3.
REQ-033 scan_next at (0,0) -> frame_start=1 exactly at T+1; at (1,0) -> frame_start=0.
REQ-034 Reset asserted at T+1 of a read -> scan_color=0, state IDLE, mem_we=0, cam_ready=1 first cycle after release.
REQ-035 cam_valid=1 with scan_next every 3 cycles for 70000 cycles -> stall_count saturates at 0xFFFF, no wrap.
